// File: rtl/debug_mem_loader.sv
// Host-framed boot loader driving the RV32I debug cache write ports and core reset.
// Optional read-back verification is enabled with `define DEBUG_MEM_LOADER_VERIFY_EN.
module debug_mem_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter bit          HOLD_ON_BOOT   = 1'b1
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        core_rst,
    output logic [31:0] inst_a2,
    output logic [31:0] inst_wd2,
    output logic [3:0]  inst_we2,
    input  logic [31:0] inst_rd2,
    output logic [31:0] data_a2,
    output logic [31:0] data_wd2,
    output logic [3:0]  data_we2,
    input  logic [31:0] data_rd2,
    output logic        busy,
    output logic [2:0]  err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_WRITE, S_VERIFY, S_READ
    } state_e;

    localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic        tgt_q, tgt_d;          // 0: instruction cache, 1: data cache
    logic [31:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic        hold_q, hold_d;
    logic [2:0]  err_q, err_d;
    logic [31:0] tmo_q, tmo_d;
    logic        rx_ready_q, rx_ready_d;
    logic [31:0] inst_a2_q, inst_a2_d, inst_wd2_q, inst_wd2_d;
    logic [31:0] data_a2_q, data_a2_d, data_wd2_q, data_wd2_d;
    logic [3:0]  inst_we2_q, inst_we2_d, data_we2_q, data_we2_d;

    logic        fire;
    logic [31:0] byte_word;
    logic [15:0] len_word;

    assign fire      = rx_valid && rx_ready_q;
    assign byte_word = {rx_data, word_q[31:8]};
    assign len_word  = {rx_data, cnt_q[15:8]};

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        inst_a2_d  = inst_a2_q;
        inst_wd2_d = inst_wd2_q;
        data_a2_d  = data_a2_q;
        data_wd2_d = data_wd2_q;
        inst_we2_d = '0;
        data_we2_d = '0;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                idx_d = '0;
                if (fire) begin
                    case (rx_data)
                        8'h49: begin state_d = S_ADDR; tgt_d = 1'b0; end
                        8'h44: begin state_d = S_ADDR; tgt_d = 1'b1; end
                        8'h47: hold_d = 1'b0;
                        8'h48: hold_d = 1'b1;
                        8'h43: err_d  = '0;
                        default: err_d[0] = 1'b1;
                    endcase
                end
            end
            S_ADDR, S_LEN, S_DATA: begin
                if (fire) begin
                    tmo_d  = '0;
                    idx_d  = idx_q + 2'd1;
                    word_d = byte_word;
                    if (state_q == S_ADDR) begin
                        if (idx_q == 2'd3) begin
                            addr_d  = {byte_word[31:2], 2'b00};
                            state_d = S_LEN;
                        end
                    end else if (state_q == S_LEN) begin
                        cnt_d = len_word;
                        if (idx_q == 2'd1) begin
                            idx_d   = '0;
                            state_d = (len_word == 16'd0) ? S_IDLE : S_DATA;
                        end
                    end else if (idx_q == 2'd3) begin
                        // Word is complete: launch the write pulse in the following cycle.
                        state_d = S_WRITE;
                        if (tgt_q) begin
                            data_a2_d  = addr_q;
                            data_wd2_d = byte_word;
                            data_we2_d = 4'hF;
                        end else begin
                            inst_a2_d  = addr_q;
                            inst_wd2_d = byte_word;
                            inst_we2_d = 4'hF;
                        end
                    end
                end else if (TIMEOUT_CYCLES != 0 && (tmo_q + 32'd1) == TMO) begin
                    err_d[1] = 1'b1;
                    state_d  = S_IDLE;
                    idx_d    = '0;
                    tmo_d    = '0;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            S_WRITE: begin
                addr_d = addr_q + 32'd4;
                cnt_d  = cnt_q - 16'd1;
`ifdef DEBUG_MEM_LOADER_VERIFY_EN
                state_d = S_VERIFY;
`else
                state_d = (cnt_q == 16'd1) ? S_IDLE : S_DATA;
`endif
            end
`ifdef DEBUG_MEM_LOADER_VERIFY_EN
            S_VERIFY: state_d = S_READ;
            S_READ: begin
                if ((tgt_q ? data_rd2 : inst_rd2) != (tgt_q ? data_wd2_q : inst_wd2_q))
                    err_d[2] = 1'b1;
                state_d = (cnt_q == 16'd0) ? S_IDLE : S_DATA;
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifndef DEBUG_MEM_LOADER_VERIFY_EN
        err_d[2] = 1'b0;
`endif
        rx_ready_d = (state_d inside {S_IDLE, S_ADDR, S_LEN, S_DATA});
    end

`ifndef DEBUG_MEM_LOADER_VERIFY_EN
    logic unused_rd2;
    assign unused_rd2 = ^{inst_rd2, data_rd2};
`endif

    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            state_q    <= S_IDLE;
            tgt_q      <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            hold_q     <= HOLD_ON_BOOT;
            err_q      <= '0;
            tmo_q      <= '0;
            rx_ready_q <= 1'b0;
            inst_a2_q  <= '0;
            inst_wd2_q <= '0;
            inst_we2_q <= '0;
            data_a2_q  <= '0;
            data_wd2_q <= '0;
            data_we2_q <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            rx_ready_q <= rx_ready_d;
            inst_a2_q  <= inst_a2_d;
            inst_wd2_q <= inst_wd2_d;
            inst_we2_q <= inst_we2_d;
            data_a2_q  <= data_a2_d;
            data_wd2_q <= data_wd2_d;
            data_we2_q <= data_we2_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign busy     = (state_q != S_IDLE);
    assign core_rst = hold_q | busy;
    assign err      = err_q;
    assign inst_a2  = inst_a2_q;
    assign inst_wd2 = inst_wd2_q;
    assign inst_we2 = inst_we2_q;
    assign data_a2  = data_a2_q;
    assign data_wd2 = data_wd2_q;
    assign data_we2 = data_we2_q;

endmodule

// File: doc/debug_mem_loader.md
# debug_mem_loader

Boot-time loader that sits directly upstream of the RV32I core's debug cache ports. It receives a framed byte stream from a host link (UART/JTAG bridge) and writes words into the instruction or data cache through the core's debug write ports. It owns the core's active-high reset, holding the core in reset until the host issues a run command.

## Interface
- TIMEOUT_CYCLES, 1_000_000: maximum idle cycles between bytes inside a frame before the frame is aborted; 0 disables the timeout.
- HOLD_ON_BOOT, 1: value of core_rst at reset; 1 holds the core in reset, 0 lets it run immediately.
- CPU_CLK  in  1  sole clock.
- CPU_RST  in  1  asynchronous, active-low reset.
- rx_valid  in  1  host byte valid.
- rx_data  in  8  host byte.
- rx_ready  out  1  loader accepts byte; transfer happens when rx_valid && rx_ready.
- core_rst  out  1  active-high reset to the core.
- inst_a2 / inst_wd2  out  32 / 32  instruction-cache debug address / write data.
- inst_we2  out  4  instruction-cache debug byte enables.
- inst_rd2  in  32  instruction-cache debug read data.
- data_a2 / data_wd2 / data_we2 / data_rd2: same four ports for the data cache.
- busy  out  1  high when the loader is outside IDLE.
- err  out  3  sticky error flags: [0] bad command, [1] timeout, [2] verify mismatch.

## Operation
- Frame format: CMD, then for 'I' (0x49) or 'D' (0x44) ADDR[4 bytes, LE], LEN[2 bytes, LE, word count], then LEN×4 data bytes (LE per word).
- 'G' (0x47) clears core_rst. 'H' (0x48) sets core_rst. 'C' (0x43) clears err. Each of these is a single-byte frame.
- Any other byte received in IDLE sets err[0] and is otherwise ignored.
- FSM states:
  - IDLE → ADDR on 'I'/'D'; the target cache is latched.
  - ADDR (4 bytes) → LEN.
  - LEN (2 bytes) → DATA if LEN≠0, else → IDLE with no writes.
  - DATA (4 bytes) → WRITE.
  - WRITE, one cycle: the target we2=4'hF, a2=addr, wd2=word. Then → VERIFY (macro on) or → DATA / IDLE.
  - VERIFY → READ → DATA / IDLE.
- Address handling: addr[1:0] is forced to 0. Addr increments by 4 after each word and wraps modulo 2^32. The remaining count decrements after each word; when it reaches 0 the FSM returns to IDLE.
- The non-target cache port always has we2=0.
- core_rst is forced to 1 while a load frame is in progress, whatever the prior G/H state. After the frame ends, the last G/H value is restored.
- Timeout: a counter resets on each accepted byte and counts while in ADDR, LEN or DATA. When it reaches TIMEOUT_CYCLES: set err[1], go to IDLE, discard the partial word.
- When a bad command and a 'C' would coincide (not possible; one byte per cycle), a set wins over a clear.

## Timing
- Reset values: rx_ready=0, core_rst=HOLD_ON_BOOT, all a2/wd2=0, all we2=0, busy=0, err=0, FSM=IDLE, counters=0.
- rx_ready=1 in IDLE, ADDR, LEN and DATA. rx_ready=0 in WRITE, VERIFY and READ.
- The 4th data byte accepted in cycle N produces we2=F in cycle N+1, for exactly one cycle.
- Throughput: 4 byte-cycles plus 1 write cycle per word (plus 2 verify cycles with the macro on).
- 'G' accepted in cycle N gives core_rst=0 from cycle N+1.
- Asynchronous reset in mid-frame: all outputs return to reset values immediately; the partial frame is lost and no write is pulsed.

## Configuration
- DEBUG_MEM_LOADER_VERIFY_EN defined:
  - VERIFY presents a2 with we2=0.
  - READ compares rd2 (synchronous cache read, valid one cycle after the address) with the written word.
  - A mismatch sets err[2]; loading continues.
- Undefined: no VERIFY/READ states. err[2] is tied to 0, and WRITE goes directly to DATA/IDLE.

## Test plan
- Load to I-cache: send 49 00 00 00 00 02 00 13 00 00 00 93 00 10 00 → we2=F at a2=0x0 with wd2=0x00000013, then at a2=0x4 with wd2=0x00100093. data_we2 stays 0 throughout; busy ends at 0; core_rst stays 1.
- Run control: after reset core_rst=1. Send 47 → core_rst=0 the next cycle. Send 48 → core_rst=1.
- Bad command and clear: send 5A → err=3'b001. Send 43 → err=0.
- Zero-length and wrap: D-load with ADDR=0xFFFFFFFE and LEN=2 → data writes at 0xFFFFFFFC, then 0x00000000. A D-load with LEN=0 → no writes, FSM back in IDLE.
- Timeout: TIMEOUT_CYCLES=16; send 49 00 00, then stall → after 16 cycles err[1]=1 and FSM in IDLE. A following 47 is obeyed.
- Verify (macro on): cache model returns the written word XOR 1 → err[2]=1 after the write. Reset asserted mid-DATA → we2=0 and rx_ready=0 immediately.
